// File: rtl/serial_divider8_if.sv
// Handshake and result bundle for the 8-bit serial restoring divider.
// master issues requests and consumes results; slave is the divider itself.
interface serial_divider8_if;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       N;
  logic       Z;
  logic       C;
  logic       V;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, N, Z, C, V
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, N, Z, C, V
  );
endinterface

// File: rtl/serial_divider8.sv
// 8-bit unsigned restoring divider, one quotient bit per cycle, MSB first.
// Divide-by-zero short-circuits to DONE with quotient FF and remainder = dividend.
module serial_divider8 (
  input  logic             clk,
  input  logic             rstn,
  serial_divider8_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [8:0] pr;
  logic [7:0] acc;
  logic [7:0] dvs;

  // Partial remainder shifted left with the next dividend bit brought in.
  logic [9:0] shifted;
  logic [9:0] diff;
  logic       borrow;

  always_comb begin
    shifted = {pr, acc[7]};
    // Trial subtraction; the top bit is the borrow.
    diff    = shifted - {2'b00, dvs};
    borrow  = diff[9];
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      pr           <= '0;
      acc          <= '0;
      dvs          <= '0;
      io.busy      <= 1'b0;
      io.done      <= 1'b0;
      io.quotient  <= '0;
      io.remainder <= '0;
      io.N         <= 1'b0;
      io.Z         <= 1'b0;
      io.C         <= 1'b0;
      io.V         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          io.done <= 1'b0;
          if (io.start) begin
            acc     <= io.dividend;
            dvs     <= io.divisor;
            pr      <= '0;
            cnt     <= '0;
            io.busy <= 1'b1;
            state   <= CALC;
          end
        end

        CALC: begin
          if (dvs == '0) begin
            // acc still holds the untouched dividend here.
            io.quotient  <= 8'hFF;
            io.remainder <= acc;
            io.N         <= 1'b1;
            io.Z         <= 1'b0;
            io.C         <= (acc != '0);
            io.V         <= 1'b1;
            io.done      <= 1'b1;
            state        <= DONE;
          end else if (cnt == 4'd8) begin
            io.quotient  <= acc;
            io.remainder <= pr[7:0];
            io.N         <= acc[7];
            io.Z         <= (acc == '0);
            io.C         <= (pr[7:0] != '0);
            io.V         <= 1'b0;
            io.done      <= 1'b1;
            state        <= DONE;
          end else begin
            pr  <= borrow ? shifted[8:0] : diff[8:0];
            acc <= {acc[6:0], ~borrow};
            cnt <= cnt + 4'd1;
          end
        end

        DONE: begin
          io.done <= 1'b0;
          io.busy <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          io.done <= 1'b0;
          io.busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_divider8.sv
// Randomized and directed checks of serial_divider8 against an arithmetic reference.
module tb_serial_divider8;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_pass;

  serial_divider8_if bus ();

  serial_divider8 dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_q"}, bus.quotient, 0);
    check({tag, "_r"}, bus.remainder, 0);
    check({tag, "_nzcv"}, {bus.N, bus.Z, bus.C, bus.V}, 0);
  endtask

  // One full division; optionally re-pulse start during CALC (lat index repulse).
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int repulse);
    logic [7:0] eq, er;
    int         exp_lat, lat;
    if (b == 0) begin
      eq = 8'hFF; er = a; exp_lat = 1;
    end else begin
      eq = a / b; er = a % b; exp_lat = 9;
    end
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    check("busy_after_accept", bus.busy, 1);
    lat = 0;
    while (!bus.done && lat < 20) begin
      if (lat == repulse) begin
        bus.start = 1'b1; bus.dividend = 8'h10; bus.divisor = 8'h02;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      lat++;
    end
    bus.start = 1'b0;
    check("latency", lat, exp_lat);
    check("quotient", bus.quotient, eq);
    check("remainder", bus.remainder, er);
    check("flag_N", bus.N, eq[7]);
    check("flag_Z", bus.Z, eq == 0);
    check("flag_C", bus.C, er != 0);
    check("flag_V", bus.V, b == 0);
    // start during DONE must be dropped
    bus.start    = 1'b1;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom_range(1, 255));
    tick();
    bus.start = 1'b0;
    check("done_one_cycle", bus.done, 0);
    check("idle_after_done", bus.busy, 0);
    check("quotient_hold", bus.quotient, eq);
    check("remainder_hold", bus.remainder, er);
  endtask

  initial begin
    int pulses;
    logic [7:0] a, b;
    n_checks     = 0;
    n_pass       = 0;
    rstn         = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 8'h55;
    bus.divisor  = 8'h03;
    tick();
    tick();
    check_all_zero("reset");
    rstn = 1'b0;

    // First edge with rstn=0 and start=1 accepts.
    run_div(8'd100, 8'd7, -1);
    run_div(8'hFF, 8'h80, -1);
    run_div(8'hFF, 8'h01, -1);
    run_div(8'h00, 8'h05, -1);
    run_div(8'h12, 8'h00, -1);
    run_div(8'h44, 8'h11, 3);

    // Abort mid-calculation.
    bus.start = 1'b1; bus.dividend = 8'hAB; bus.divisor = 8'h12;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rstn = 1'b1;
    tick();
    check_all_zero("abort");
    rstn   = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_div(8'hAB, 8'h12, -1);

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_div(a, b, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
